// File: rtl/config_arb_pkg.sv
// Shared encodings for the eFPGA config-port arbiter.
package config_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UART_OWN = 2'd1,
    ST_JTAG_OWN = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_UART = 2'd1;
  localparam logic [1:0] OWNER_JTAG = 2'd2;

endpackage

// File: rtl/config_source_arbiter.sv
// Arbitrates the eFPGA config write port between the UART loader and the
// JTAG TAP. Ownership is held for a whole bitstream, a guard period follows
// the owner's active drop, owner words are forwarded with one cycle latency,
// and writes from non-owners are counted and flagged.
module config_source_arbiter
  import config_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int GUARD_CYCLES   = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      uart_active,
  input  logic [DATA_WIDTH-1:0]     uart_write_data,
  input  logic                      uart_write_strobe,
  input  logic                      jtag_active,
  input  logic [DATA_WIDTH-1:0]     jtag_write_data,
  input  logic                      jtag_write_strobe,
  input  logic                      clear_conflict,
  output logic [DATA_WIDTH-1:0]     config_write_data,
  output logic                      config_write_strobe,
  output logic                      com_active,
  output logic [1:0]                owner,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count,
  output logic                      conflict_flag
);

  // Guard counter only ever holds GUARD_CYCLES-1 down to 0.
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  arb_state_e          state;
  logic [GW-1:0]       guard_cnt;
  logic                prev_jtag;   // which source owned before RELEASE

  logic                acc_u, acc_j;
  logic                rej_u, rej_j;
  logic [1:0]          rej_n;
  logic [DROP_CNT_WIDTH-1:0] cnt_base;
  logic [DROP_CNT_WIDTH:0]   cnt_sum;

  // Strobe acceptance depends only on the current state and this cycle's
  // inputs; in IDLE the same-cycle winner's strobe already counts.
  always_comb begin
    acc_u = 1'b0;
    acc_j = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_j = jtag_write_strobe & jtag_active;
        acc_u = uart_write_strobe & uart_active & ~jtag_active;
      end
      ST_UART_OWN: acc_u = uart_write_strobe;
      ST_JTAG_OWN: acc_j = jtag_write_strobe;
      default: ;
    endcase
    rej_u    = uart_write_strobe & ~acc_u;
    rej_j    = jtag_write_strobe & ~acc_j;
    rej_n    = {1'b0, rej_u} + {1'b0, rej_j};
    cnt_base = clear_conflict ? '0 : dropped_count;
    cnt_sum  = {1'b0, cnt_base} + (DROP_CNT_WIDTH + 1)'(rej_n);
  end

  // Ownership FSM with registered owner / com_active.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      guard_cnt  <= '0;
      prev_jtag  <= 1'b0;
      owner      <= OWNER_NONE;
      com_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jtag_active) begin
            state      <= ST_JTAG_OWN;
            owner      <= OWNER_JTAG;
            com_active <= 1'b1;
          end else if (uart_active) begin
            state      <= ST_UART_OWN;
            owner      <= OWNER_UART;
            com_active <= 1'b1;
          end
        end
        ST_UART_OWN: begin
          if (!uart_active) begin
            state     <= ST_RELEASE;
            prev_jtag <= 1'b0;
            guard_cnt <= GUARD_LOAD;
          end
        end
        ST_JTAG_OWN: begin
          if (!jtag_active) begin
            state     <= ST_RELEASE;
            prev_jtag <= 1'b1;
            guard_cnt <= GUARD_LOAD;
          end
        end
        ST_RELEASE: begin
          // Reclaim by the previous owner beats guard expiry.
          if (prev_jtag ? jtag_active : uart_active) begin
            state <= prev_jtag ? ST_JTAG_OWN : ST_UART_OWN;
          end else if (guard_cnt == '0) begin
            state      <= ST_IDLE;
            owner      <= OWNER_NONE;
            com_active <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Forward the accepted word; data holds between strobes.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      config_write_data   <= '0;
      config_write_strobe <= 1'b0;
    end else begin
      config_write_strobe <= acc_u | acc_j;
      if (acc_j)      config_write_data <= jtag_write_data;
      else if (acc_u) config_write_data <= uart_write_data;
    end
  end

  // Saturating drop counter and sticky conflict flag; a clear in the same
  // cycle as a rejection leaves only that cycle's rejections.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      dropped_count <= '0;
      conflict_flag <= 1'b0;
    end else begin
      dropped_count <= cnt_sum[DROP_CNT_WIDTH] ? '1 : cnt_sum[DROP_CNT_WIDTH-1:0];
      conflict_flag <= (clear_conflict ? 1'b0 : conflict_flag) | (rej_n != 2'd0);
    end
  end

endmodule

// File: doc/config_source_arbiter.md
Name: config_source_arbiter

Overview:
- Arbitrates the eFPGA configuration write port between two config sources: the UART bitstream loader and the JTAG TAP.
- Sits between those sources and the frame config logic that consumes SelfWriteData/SelfWriteStrobe-style words.
- Locks ownership to one source for a whole bitstream, adds a guard period before handover, and forwards the owner's 32-bit words with one cycle of latency.
- Counts and flags writes from non-owners.

Parameters:
- DATA_WIDTH, 32: config word width.
- GUARD_CYCLES, 16: idle cycles after the owner's active flag drops before ownership is released. Legal range ≥ 1.
- DROP_CNT_WIDTH, 8: width of the saturating dropped-write counter.

Ports:
- CLK  in  1  system clock. All logic runs on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- uart_active  in  1  UART loader is in a bitstream transfer.
- uart_write_data  in  DATA_WIDTH  UART config word.
- uart_write_strobe  in  1  single-cycle write qualifier for uart_write_data.
- jtag_active  in  1  TAP is in config mode.
- jtag_write_data  in  DATA_WIDTH  JTAG config word.
- jtag_write_strobe  in  1  single-cycle write qualifier for jtag_write_data.
- clear_conflict  in  1  clears conflict_flag and dropped_count.
- config_write_data  out  DATA_WIDTH  forwarded word, registered.
- config_write_strobe  out  1  forwarded strobe, registered, one pulse per accepted word.
- com_active  out  1  high whenever state != IDLE, registered.
- owner  out  2  0 = none, 1 = UART, 2 = JTAG, registered.
- dropped_count  out  DROP_CNT_WIDTH  saturating count of rejected strobes.
- conflict_flag  out  1  sticky; set by any rejected strobe.

Behaviour:
- **Reset:** state = IDLE, guard counter = 0. Every output is 0, including config_write_data.
- **States:** IDLE, UART_OWN, JTAG_OWN, RELEASE. RELEASE remembers the previous owner.
- **IDLE:**
  - jtag_active → JTAG_OWN.
  - Else uart_active → UART_OWN.
  - JTAG has fixed priority when both are active in the same cycle.
  - A strobe from the winning source in that same cycle is accepted. A strobe from the loser is rejected.
  - A strobe from a source with active low is rejected.
- **X_OWN:**
  - An owner strobe is accepted: config_write_data and config_write_strobe update on the next edge (latency 1).
  - The other source's strobe is rejected, even if that source's active is high.
  - Owner active low → RELEASE; guard counter loads GUARD_CYCLES-1.
  - An owner strobe in the cycle active drops is still accepted.
- **RELEASE:**
  - No forwarding. All strobes are rejected.
  - Counter decrements each cycle.
  - Previous owner reasserting active → back to X_OWN on the next edge. This takes priority over expiry.
  - Counter == 0 with no reassert → IDLE. The other source's active is ignored until IDLE is reached.
- **Strobe output:** config_write_strobe is 0 in every cycle that does not follow an accepted strobe. config_write_data holds its last value.
- **Rejected strobe:**
  - dropped_count increments, saturating at all-ones with no wrap.
  - conflict_flag is set.
  - Rejections from both sources in one cycle count as 2. Saturation still applies.
- **clear_conflict:**
  - Zeroes the count and flag.
  - If a rejection occurs in the same cycle, the result is count = number rejected that cycle and flag = 1.
- **Output timing:** owner and com_active reflect state after the edge. com_active = (state != IDLE).
- **Reset mid-operation:** immediate return to reset values. No partial word is emitted.

Decomposition:
- Package config_arb_pkg holds:
  - state encoding (IDLE = 0, UART_OWN = 1, JTAG_OWN = 2, RELEASE = 3);
  - owner codes OWNER_NONE = 0, OWNER_UART = 1, OWNER_JTAG = 2.
- No sub-module is required. The saturating counter stays inline.

Test Plan:
1. **UART only:** uart_active = 1, strobes with 0xDEADBEEF and 0x00000001 in consecutive cycles → config_write_strobe pulses one cycle after each with matching data; owner = 1; dropped_count = 0.
2. **Simultaneous request:** from IDLE, both active and both strobe in one cycle (jtag 0xAAAA5555, uart 0x12345678) → owner = 2; output 0xAAAA5555; dropped_count = 1; conflict_flag = 1.
3. **Guard handover:** JTAG owns, jtag_active drops, uart_active high throughout → owner stays 2 for GUARD_CYCLES cycles, then IDLE, then UART_OWN on the next edge; UART strobes during the guard are rejected and counted.
4. **Owner reclaim:** jtag_active drops, then reasserts after 5 cycles (GUARD_CYCLES = 16) → returns to JTAG_OWN without passing IDLE; com_active stays 1 throughout.
5. **Saturation and clear:**
   - With DROP_CNT_WIDTH = 8, 300 rejected strobes → dropped_count = 255.
   - clear_conflict alone → 0, flag 0.
   - clear_conflict plus one rejection in the same cycle → 1, flag 1.
6. **Async reset:** resetn low mid-transfer, between clock edges → all outputs 0 immediately; no strobe after release until a new grant.
